// File: rtl/serial_link_pkg.sv
// Shared types and header encoding for the outbound serial link (TX scheduler and RX deframer).
package serial_link_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR     = 2'd1,
      PAYLOAD = 2'd2
   } sl_tx_state_e;

   localparam logic [3:0] SL_HDR_MAGIC = 4'hA;

   // Header byte: magic nibble over the 4-bit channel number.
   function automatic logic [7:0] sl_hdr(input logic [3:0] ch);
      return {SL_HDR_MAGIC, ch};
   endfunction

endpackage

// File: rtl/serial_link_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping; the pointer register lives outside.
module serial_link_rr_arb #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] idx_o
);

   logic [PW:0] sum;
   logic        found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      sum   = '0;
      for (int i = 0; i < N; i++) begin
         // One extra bit keeps ptr+i from wrapping before the explicit mod-N fold.
         sum = {1'b0, ptr_i} + (PW+1)'(i);
         if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
         if (!found && req_i[sum[PW-1:0]]) begin
            found               = 1'b1;
            gnt_o[sum[PW-1:0]]  = 1'b1;
            idx_o               = sum[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/serial_link_tx_scheduler.sv
// Round-robin, credit-flow-controlled framer sharing the DDR TX link: header beat then LSB-first payload beats.
module serial_link_tx_scheduler
   import serial_link_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int DATA_W  = 32,
   parameter int LANE_W  = 8,
   parameter int CREDITS = 8
) (
   input  logic                         clk_gen,
   input  logic                         rst_n,
   input  logic [N_CH-1:0]              req_valid_i,
   input  logic [N_CH*DATA_W-1:0]       req_data_i,
   output logic [N_CH-1:0]              req_ready_o,
   input  logic                         credit_return_i,
   input  logic                         link_full_i,
   output logic [LANE_W-1:0]            tx_data_o,
   output logic                         tx_valid_o,
   output logic                         tx_sof_o,
   output logic                         busy_o,
   output logic [$clog2(CREDITS+1)-1:0] credits_o,
   output logic                         credit_err_o,
   output sl_tx_state_e                 state_o
);

   localparam int BEATS = DATA_W / LANE_W;
   localparam int PW    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CRW   = $clog2(CREDITS + 1);

   // Handshake: a channel's word is taken at the posedge where req_valid_i[c] & req_ready_o[c];
   // ready is offered only in IDLE, is one-hot, and may be seen combinationally in the same cycle.

   sl_tx_state_e                    state_q, state_d;
   logic [CW-1:0]                   cnt_q, cnt_d, cnt_nx;
   logic [BEATS-1:0][LANE_W-1:0]    word_q, word_d;
   logic [PW-1:0]                   rr_q, rr_d;
   logic [CRW-1:0]                  credits_q, credits_d;
   logic                            err_q, err_d;
   logic [LANE_W-1:0]               tx_data_q, tx_data_d;
   logic                            tx_valid_q, tx_valid_d, tx_sof_q, tx_sof_d;

   logic [N_CH-1:0][DATA_W-1:0]     req_words;
   logic [N_CH-1:0]                 arb_gnt;
   logic [PW-1:0]                   arb_idx;
   logic                            eligible, grant;

   assign req_words = req_data_i;

   serial_link_rr_arb #(.N(N_CH), .PW(PW)) u_arb (
      .req_i (req_valid_i),
      .ptr_i (rr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   // rst_n is folded in so no grant is offered while the block is held in reset.
   assign eligible = rst_n & (|req_valid_i) & (credits_q != '0) & ~link_full_i;
   assign cnt_nx   = cnt_q + CW'(1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      rr_d        = rr_q;
      tx_data_d   = '0;
      tx_valid_d  = 1'b0;
      tx_sof_d    = 1'b0;
      req_ready_o = '0;
      grant       = 1'b0;
      case (state_q)
         IDLE: begin
            if (eligible) begin
               req_ready_o = arb_gnt;
               grant       = 1'b1;
               word_d      = req_words[arb_idx];
               rr_d        = (arb_idx == PW'(N_CH - 1)) ? '0 : arb_idx + PW'(1);
               state_d     = HDR;
               tx_valid_d  = 1'b1;
               tx_sof_d    = 1'b1;
               tx_data_d   = LANE_W'(sl_hdr(4'(arb_idx)));
            end
         end
         HDR: begin
            state_d    = PAYLOAD;
            cnt_d      = '0;
            tx_valid_d = 1'b1;
            tx_data_d  = word_q[0];
         end
         PAYLOAD: begin
            if (cnt_q == CW'(BEATS - 1)) begin
               state_d = IDLE;
            end else begin
               cnt_d      = cnt_nx;
               tx_valid_d = 1'b1;
               tx_data_d  = word_q[cnt_nx];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A grant and a return in the same cycle cancel; a return at full count saturates and flags.
   always_comb begin
      credits_d = credits_q;
      err_d     = err_q;
      if (grant && !credit_return_i) begin
         credits_d = credits_q - CRW'(1);
      end else if (!grant && credit_return_i) begin
         if (credits_q == CRW'(CREDITS)) err_d = 1'b1;
         else                            credits_d = credits_q + CRW'(1);
      end
   end

   always_ff @(posedge clk_gen or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         word_q     <= '0;
         rr_q       <= '0;
         credits_q  <= CRW'(CREDITS);
         err_q      <= 1'b0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         tx_sof_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         rr_q       <= rr_d;
         credits_q  <= credits_d;
         err_q      <= err_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         tx_sof_q   <= tx_sof_d;
      end
   end

   assign tx_data_o    = tx_data_q;
   assign tx_valid_o   = tx_valid_q;
   assign tx_sof_o     = tx_sof_q;
   assign busy_o       = (state_q != IDLE);
   assign credits_o    = credits_q;
   assign credit_err_o = err_q;
   assign state_o      = state_q;

endmodule
